// File: rtl/ibex_pkg.sv
// Shared Ibex types used by the writeback queue.
package ibex_pkg;

    // Classifies an instruction for the writeback stage.
    typedef enum logic [1:0] {
        WB_INSTR_LOAD,
        WB_INSTR_STORE,
        WB_INSTR_OTHER
    } wb_instr_type_e;

endpackage

// File: rtl/ibex_wb_queue.sv
// Writeback queue: a circular FIFO of in-flight instructions between ID/EX
// and the register file. Loads and stores wait for their LSU response.
// Everything else retires as soon as it reaches the head. Retirement is
// strictly in order, at most one entry per cycle.
module ibex_wb_queue
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   setback_i,

    input  logic                   en_wb_i,
    input  wb_instr_type_e         instr_type_wb_i,
    input  logic [31:0]            pc_id_i,
    input  logic                   instr_is_compressed_id_i,
    input  logic                   instr_perf_count_id_i,

    input  logic [4:0]             rf_waddr_id_i,
    input  logic [31:0]            rf_wdata_id_i,
    input  logic                   rf_we_id_i,

    input  logic                   lsu_resp_valid_i,
    input  logic                   lsu_resp_err_i,
    input  logic [31:0]            rf_wdata_lsu_i,
    input  logic                   rf_we_lsu_i,

    output logic                   ready_wb_o,

    output logic [4:0]             rf_waddr_wb_o,
    output logic [31:0]            rf_wdata_wb_o,
    output logic                   rf_we_wb_o,
    output logic [31:0]            rf_pending_wb_o,

    output logic                   outstanding_load_wb_o,
    output logic                   outstanding_store_wb_o,
    output logic [31:0]            pc_wb_o,
    output logic                   instr_done_wb_o,

    output logic                   perf_instr_ret_wb_o,
    output logic                   perf_instr_ret_compressed_wb_o,
    output logic [$clog2(Depth):0] occupancy_o
);

    // Depth is a power of two, so pointers wrap naturally at PtrW bits.
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned OccW = PtrW + 1;

    // Control state (reset)
    logic [Depth-1:0]  valid_q;
    logic [Depth-1:0]  done_q;
    logic [Depth-1:0]  err_q;
    logic [PtrW-1:0]   head_q;
    logic [PtrW-1:0]   tail_q;
    logic [OccW-1:0]   occ_q;

    // Entry payload (not reset; qualified by valid_q)
    wb_instr_type_e    type_q      [Depth];
    logic [31:0]       pc_q        [Depth];
    logic [4:0]        waddr_q     [Depth];
    logic [31:0]       id_wdata_q  [Depth];
    logic [31:0]       lsu_wdata_q [Depth];
    logic [Depth-1:0]  id_we_q;
    logic [Depth-1:0]  lsu_we_q;
    logic [Depth-1:0]  compressed_q;
    logic [Depth-1:0]  perf_q;

    // LSU response routing
    logic              resp_found;
    logic [PtrW-1:0]   resp_idx;
    logic [PtrW-1:0]   scan_idx;
    logic              resp_hit;
    logic              resp_at_head;

    // Head view
    logic              head_valid;
    wb_instr_type_e    head_type;
    logic              head_done;
    logic              head_err;
    logic              load_we;
    logic [31:0]       load_wdata;
    logic              retire;
    logic              enq;

    // Find the oldest valid load/store that is still waiting, scanning from the head.
    always_comb begin
        resp_found = 1'b0;
        resp_idx   = head_q;
        scan_idx   = head_q;
        for (int unsigned i = 0; i < Depth; i++) begin
            scan_idx = head_q + PtrW'(i);
            if (!resp_found && valid_q[scan_idx] && !done_q[scan_idx] &&
                (type_q[scan_idx] != WB_INSTR_OTHER)) begin
                resp_found = 1'b1;
                resp_idx   = scan_idx;
            end
        end
    end

    // A flush discards the response together with every entry it could target.
    assign resp_hit     = lsu_resp_valid_i & resp_found & ~setback_i;
    assign resp_at_head = resp_hit & (resp_idx == head_q);

    assign head_valid = valid_q[head_q];
    assign head_type  = type_q[head_q];
    assign head_done  = done_q[head_q];

    // A load/store head that is not yet done can only retire through the
    // same-cycle bypass, so the live response fields are the right source.
    assign load_we    = head_done ? lsu_we_q[head_q]    : (rf_we_lsu_i & ~lsu_resp_err_i);
    assign load_wdata = head_done ? lsu_wdata_q[head_q] : rf_wdata_lsu_i;
    assign head_err   = (head_type != WB_INSTR_OTHER) &
                        (head_done ? err_q[head_q] : lsu_resp_err_i);

    assign retire = ~setback_i & head_valid &
                    ((head_type == WB_INSTR_OTHER) | head_done | resp_at_head);

    // A full queue still accepts when its head leaves in the same cycle.
    assign ready_wb_o  = (occ_q < OccW'(Depth)) | retire;
    assign enq         = en_wb_i & ready_wb_o & ~setback_i;
    assign occupancy_o = occ_q;

    // Register-file write port and retirement signals, all zero when idle.
    always_comb begin
        instr_done_wb_o                = retire;
        rf_waddr_wb_o                  = '0;
        rf_wdata_wb_o                  = '0;
        rf_we_wb_o                     = 1'b0;
        perf_instr_ret_wb_o            = 1'b0;
        perf_instr_ret_compressed_wb_o = 1'b0;
        if (retire) begin
            rf_waddr_wb_o = waddr_q[head_q];
            unique case (head_type)
                WB_INSTR_LOAD: begin
                    rf_we_wb_o    = load_we;
                    rf_wdata_wb_o = load_wdata;
                end
                WB_INSTR_STORE: begin
                    rf_we_wb_o    = 1'b0;
                    rf_wdata_wb_o = id_wdata_q[head_q];
                end
                default: begin
                    rf_we_wb_o    = id_we_q[head_q];
                    rf_wdata_wb_o = id_wdata_q[head_q];
                end
            endcase
            perf_instr_ret_wb_o            = perf_q[head_q] & ~head_err;
            perf_instr_ret_compressed_wb_o = perf_q[head_q] & ~head_err &
                                             compressed_q[head_q];
        end
    end

    assign pc_wb_o = head_valid ? pc_q[head_q] : 32'h0;

    // Registers with a write in flight; loads count even before their data arrives.
    always_comb begin
        rf_pending_wb_o = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (valid_q[i] && (id_we_q[i] || (type_q[i] == WB_INSTR_LOAD))) begin
                rf_pending_wb_o[waddr_q[i]] = 1'b1;
            end
        end
        rf_pending_wb_o[0] = 1'b0;
    end

    // Flag any load or store still waiting for its LSU response.
    always_comb begin
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (valid_q[i] && !done_q[i]) begin
                if (type_q[i] == WB_INSTR_LOAD) begin
                    outstanding_load_wb_o = 1'b1;
                end
                if (type_q[i] == WB_INSTR_STORE) begin
                    outstanding_store_wb_o = 1'b1;
                end
            end
        end
    end

    // Queue control: completion, then retire, then enqueue, so an enqueue into
    // the slot freed by a same-cycle retire leaves a clean fresh entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
        end else if (setback_i) begin
            valid_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
        end else begin
            if (resp_hit) begin
                done_q[resp_idx] <= 1'b1;
                err_q[resp_idx]  <= lsu_resp_err_i;
            end
            if (retire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                err_q[tail_q]   <= 1'b0;
                tail_q          <= tail_q + PtrW'(1);
            end
            occ_q <= occ_q + OccW'(enq) - OccW'(retire);
        end
    end

    // Entry payload capture: ID fields on enqueue, LSU result on completion.
    always_ff @(posedge clk_i) begin
        if (resp_hit) begin
            lsu_wdata_q[resp_idx] <= rf_wdata_lsu_i;
            lsu_we_q[resp_idx]    <= rf_we_lsu_i & ~lsu_resp_err_i;
        end
        if (enq) begin
            type_q[tail_q]       <= instr_type_wb_i;
            pc_q[tail_q]         <= pc_id_i;
            waddr_q[tail_q]      <= rf_waddr_id_i;
            id_wdata_q[tail_q]   <= rf_wdata_id_i;
            id_we_q[tail_q]      <= rf_we_id_i;
            compressed_q[tail_q] <= instr_is_compressed_id_i;
            perf_q[tail_q]       <= instr_perf_count_id_i;
        end
    end

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Scenario bench for ibex_wb_queue with an in-order retirement scoreboard.
module tb_ibex_wb_queue;
    import ibex_pkg::*;

    localparam int Depth = 4;
    localparam int OccW  = $clog2(Depth) + 1;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            setback_i;
    logic            en_wb_i;
    wb_instr_type_e  instr_type_wb_i;
    logic [31:0]     pc_id_i;
    logic            instr_is_compressed_id_i;
    logic            instr_perf_count_id_i;
    logic [4:0]      rf_waddr_id_i;
    logic [31:0]     rf_wdata_id_i;
    logic            rf_we_id_i;
    logic            lsu_resp_valid_i;
    logic            lsu_resp_err_i;
    logic [31:0]     rf_wdata_lsu_i;
    logic            rf_we_lsu_i;
    logic            ready_wb_o;
    logic [4:0]      rf_waddr_wb_o;
    logic [31:0]     rf_wdata_wb_o;
    logic            rf_we_wb_o;
    logic [31:0]     rf_pending_wb_o;
    logic            outstanding_load_wb_o;
    logic            outstanding_store_wb_o;
    logic [31:0]     pc_wb_o;
    logic            instr_done_wb_o;
    logic            perf_instr_ret_wb_o;
    logic            perf_instr_ret_compressed_wb_o;
    logic [OccW-1:0] occupancy_o;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic        perf;
        logic        perf_c;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ibex_wb_queue #(.Depth(Depth)) dut (
        .clk_i                          (clk),
        .rst_i                          (rst_i),
        .setback_i                      (setback_i),
        .en_wb_i                        (en_wb_i),
        .instr_type_wb_i                (instr_type_wb_i),
        .pc_id_i                        (pc_id_i),
        .instr_is_compressed_id_i       (instr_is_compressed_id_i),
        .instr_perf_count_id_i          (instr_perf_count_id_i),
        .rf_waddr_id_i                  (rf_waddr_id_i),
        .rf_wdata_id_i                  (rf_wdata_id_i),
        .rf_we_id_i                     (rf_we_id_i),
        .lsu_resp_valid_i               (lsu_resp_valid_i),
        .lsu_resp_err_i                 (lsu_resp_err_i),
        .rf_wdata_lsu_i                 (rf_wdata_lsu_i),
        .rf_we_lsu_i                    (rf_we_lsu_i),
        .ready_wb_o                     (ready_wb_o),
        .rf_waddr_wb_o                  (rf_waddr_wb_o),
        .rf_wdata_wb_o                  (rf_wdata_wb_o),
        .rf_we_wb_o                     (rf_we_wb_o),
        .rf_pending_wb_o                (rf_pending_wb_o),
        .outstanding_load_wb_o          (outstanding_load_wb_o),
        .outstanding_store_wb_o         (outstanding_store_wb_o),
        .pc_wb_o                        (pc_wb_o),
        .instr_done_wb_o                (instr_done_wb_o),
        .perf_instr_ret_wb_o            (perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o (perf_instr_ret_compressed_wb_o),
        .occupancy_o                    (occupancy_o)
    );

    task automatic drive_idle();
        setback_i                = 1'b0;
        en_wb_i                  = 1'b0;
        instr_type_wb_i          = WB_INSTR_OTHER;
        pc_id_i                  = '0;
        instr_is_compressed_id_i = 1'b0;
        instr_perf_count_id_i    = 1'b0;
        rf_waddr_id_i            = '0;
        rf_wdata_id_i            = '0;
        rf_we_id_i               = 1'b0;
        lsu_resp_valid_i         = 1'b0;
        lsu_resp_err_i           = 1'b0;
        rf_wdata_lsu_i           = '0;
        rf_we_lsu_i              = 1'b0;
    endtask

    task automatic drive_enq(input wb_instr_type_e t, input logic [4:0] wa, input logic [31:0] wd,
                             input logic we, input logic perf, input logic comp, input logic [31:0] pc);
        en_wb_i                  = 1'b1;
        instr_type_wb_i          = t;
        rf_waddr_id_i            = wa;
        rf_wdata_id_i            = wd;
        rf_we_id_i               = we;
        instr_perf_count_id_i    = perf;
        instr_is_compressed_id_i = comp;
        pc_id_i                  = pc;
    endtask

    task automatic drive_resp(input logic [31:0] d, input logic err);
        lsu_resp_valid_i = 1'b1;
        lsu_resp_err_i   = err;
        rf_wdata_lsu_i   = d;
        rf_we_lsu_i      = 1'b1;
    endtask

    task automatic push_exp(input logic [4:0] wa, input logic [31:0] wd, input logic we,
                            input logic perf, input logic perf_c);
        exp_t e;
        e.waddr = wa; e.wdata = wd; e.we = we; e.perf = perf; e.perf_c = perf_c;
        sb.push_back(e);
    endtask

    // Wait for the falling edge and pop the scoreboard for any retirement seen.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (instr_done_wb_o === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_retire: got waddr=%0d we=%b, required no retire", rf_waddr_wb_o, rf_we_wb_o);
            end else begin
                e = sb.pop_front();
                if (rf_waddr_wb_o !== e.waddr) begin fails++; $display("FAIL sb_waddr: got %0d required %0d", rf_waddr_wb_o, e.waddr); end
                tests++;
                if (rf_we_wb_o !== e.we) begin fails++; $display("FAIL sb_we x%0d: got %b required %b", e.waddr, rf_we_wb_o, e.we); end
                tests++;
                if (e.we && rf_wdata_wb_o !== e.wdata) begin fails++; $display("FAIL sb_wdata x%0d: got %h required %h", e.waddr, rf_wdata_wb_o, e.wdata); end
                tests++;
                if (perf_instr_ret_wb_o !== e.perf) begin fails++; $display("FAIL sb_perf x%0d: got %b required %b", e.waddr, perf_instr_ret_wb_o, e.perf); end
                tests++;
                if (perf_instr_ret_compressed_wb_o !== e.perf_c) begin fails++; $display("FAIL sb_perf_c x%0d: got %b required %b", e.waddr, perf_instr_ret_compressed_wb_o, e.perf_c); end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (ready_wb_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", ready_wb_o); end
        tests++; if (instr_done_wb_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", instr_done_wb_o); end
        tests++; if (rf_we_wb_o !== 1'b0) begin fails++; $display("FAIL reset_we: got %b required 0", rf_we_wb_o); end
        tests++; if (rf_waddr_wb_o !== 5'd0) begin fails++; $display("FAIL reset_waddr: got %0d required 0", rf_waddr_wb_o); end
        tests++; if (rf_wdata_wb_o !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h required 0", rf_wdata_wb_o); end
        tests++; if (rf_pending_wb_o !== 32'h0) begin fails++; $display("FAIL reset_pending: got %h required 0", rf_pending_wb_o); end
        tests++; if (outstanding_load_wb_o !== 1'b0 || outstanding_store_wb_o !== 1'b0) begin fails++; $display("FAIL reset_outstanding: got %b%b required 00", outstanding_load_wb_o, outstanding_store_wb_o); end
        tests++; if (pc_wb_o !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h required 0", pc_wb_o); end
        tests++; if (perf_instr_ret_wb_o !== 1'b0 || perf_instr_ret_compressed_wb_o !== 1'b0) begin fails++; $display("FAIL reset_perf: got %b%b required 00", perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o); end
        tests++; if (occupancy_o !== '0) begin fails++; $display("FAIL reset_occupancy: got %0d required 0", occupancy_o); end
        @(negedge clk);
        rst_i = 1'b0;
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pend;
        logic        exp_done;
        for (int c = 0; c < 6; c++) begin
            drive_idle();
            if (c < 4) begin
                drive_enq(WB_INSTR_OTHER, 5'(5 + c), 32'hA000_0000 + 32'(c), 1'b1, 1'b1, (c % 2) == 1, 32'h100 + 32'(4 * c));
                push_exp(5'(5 + c), 32'hA000_0000 + 32'(c), 1'b1, 1'b1, (c % 2) == 1);
            end
            sample();
            exp_pend = (c >= 1 && c <= 4) ? (32'h1 << (4 + c)) : 32'h0;
            exp_done = (c >= 1 && c <= 4);
            tests++; if (rf_pending_wb_o !== exp_pend) begin fails++; $display("FAIL b2b_pending c%0d: got %h required %h", c, rf_pending_wb_o, exp_pend); end
            tests++; if (instr_done_wb_o !== exp_done) begin fails++; $display("FAIL b2b_done c%0d: got %b required %b", c, instr_done_wb_o, exp_done); end
            tests++; if (ready_wb_o !== 1'b1) begin fails++; $display("FAIL b2b_ready c%0d: got %b required 1", c, ready_wb_o); end
            if (exp_done) begin
                tests++; if (pc_wb_o !== 32'h100 + 32'(4 * (c - 1))) begin fails++; $display("FAIL b2b_pc c%0d: got %h required %h", c, pc_wb_o, 32'h100 + 32'(4 * (c - 1))); end
            end
            advance();
        end
    endtask

    task automatic test_load_bypass();
        drive_idle();
        drive_enq(WB_INSTR_LOAD, 5'd10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200);
        push_exp(5'd10, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        sample();
        tests++; if (outstanding_load_wb_o !== 1'b0) begin fails++; $display("FAIL ld_outst_c0: got %b required 0", outstanding_load_wb_o); end
        advance();
        drive_idle();
        drive_enq(WB_INSTR_OTHER, 5'd11, 32'h0000_1111, 1'b1, 1'b1, 1'b1, 32'h204);
        push_exp(5'd11, 32'h0000_1111, 1'b1, 1'b1, 1'b1);
        sample();
        tests++; if (outstanding_load_wb_o !== 1'b1) begin fails++; $display("FAIL ld_outst_c1: got %b required 1", outstanding_load_wb_o); end
        tests++; if (rf_pending_wb_o !== 32'h0000_0400) begin fails++; $display("FAIL ld_pending_c1: got %h required 00000400", rf_pending_wb_o); end
        advance();
        drive_idle();
        sample();
        tests++; if (instr_done_wb_o !== 1'b0) begin fails++; $display("FAIL ld_done_c2: got %b required 0", instr_done_wb_o); end
        tests++; if (rf_pending_wb_o !== 32'h0000_0C00) begin fails++; $display("FAIL ld_pending_c2: got %h required 00000c00", rf_pending_wb_o); end
        tests++; if (occupancy_o !== OccW'(2)) begin fails++; $display("FAIL ld_occ_c2: got %0d required 2", occupancy_o); end
        advance();
        drive_resp(32'hDEAD_BEEF, 1'b0);
        sample();
        tests++; if (instr_done_wb_o !== 1'b1 || rf_waddr_wb_o !== 5'd10) begin fails++; $display("FAIL ld_bypass_c3: got done=%b waddr=%0d required done=1 waddr=10", instr_done_wb_o, rf_waddr_wb_o); end
        advance();
        drive_idle();
        sample();
        tests++; if (instr_done_wb_o !== 1'b1 || rf_waddr_wb_o !== 5'd11) begin fails++; $display("FAIL ld_follow_c4: got done=%b waddr=%0d required done=1 waddr=11", instr_done_wb_o, rf_waddr_wb_o); end
        tests++; if (outstanding_load_wb_o !== 1'b0) begin fails++; $display("FAIL ld_outst_c4: got %b required 0", outstanding_load_wb_o); end
        advance();
        sample();
        tests++; if (occupancy_o !== '0) begin fails++; $display("FAIL ld_occ_c5: got %0d required 0", occupancy_o); end
        advance();
    endtask

    task automatic test_full_wrap();
        rst_i = 1'b1;
        drive_idle();
        advance();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_idle();
            drive_enq(WB_INSTR_LOAD, 5'(1 + k), 32'h0, 1'b0, 1'b1, 1'b0, 32'h300 + 32'(4 * k));
            push_exp(5'(1 + k), 32'hC0DE_0000 + 32'(k), 1'b1, 1'b1, 1'b0);
            sample();
            tests++; if (ready_wb_o !== 1'b1) begin fails++; $display("FAIL full_fill_ready k%0d: got %b required 1", k, ready_wb_o); end
            advance();
        end
        drive_idle();
        drive_enq(WB_INSTR_OTHER, 5'd9, 32'h0000_9999, 1'b1, 1'b1, 1'b0, 32'h310);
        sample();
        tests++; if (ready_wb_o !== 1'b0) begin fails++; $display("FAIL full_blocked_ready: got %b required 0", ready_wb_o); end
        tests++; if (occupancy_o !== OccW'(4)) begin fails++; $display("FAIL full_occ: got %0d required 4", occupancy_o); end
        advance();
        drive_resp(32'hC0DE_0000, 1'b0);
        push_exp(5'd9, 32'h0000_9999, 1'b1, 1'b1, 1'b0);
        sample();
        tests++; if (ready_wb_o !== 1'b1) begin fails++; $display("FAIL full_retire_ready: got %b required 1", ready_wb_o); end
        tests++; if (instr_done_wb_o !== 1'b1) begin fails++; $display("FAIL full_retire_done: got %b required 1", instr_done_wb_o); end
        advance();
        for (int k = 1; k < 4; k++) begin
            drive_idle();
            drive_resp(32'hC0DE_0000 + 32'(k), 1'b0);
            sample();
            tests++; if (occupancy_o !== OccW'(5 - k)) begin fails++; $display("FAIL full_drain_occ k%0d: got %0d required %0d", k, occupancy_o, 5 - k); end
            advance();
        end
        drive_idle();
        sample();
        tests++; if (instr_done_wb_o !== 1'b1 || rf_waddr_wb_o !== 5'd9) begin fails++; $display("FAIL full_wrapped_entry: got done=%b waddr=%0d required done=1 waddr=9", instr_done_wb_o, rf_waddr_wb_o); end
        advance();
        sample();
        tests++; if (occupancy_o !== '0 || sb.size() != 0) begin fails++; $display("FAIL full_empty: got occ=%0d left=%0d required 0/0", occupancy_o, sb.size()); end
        advance();
    endtask

    task automatic test_load_error();
        drive_idle();
        drive_enq(WB_INSTR_LOAD, 5'd12, 32'h0, 1'b0, 1'b1, 1'b1, 32'h400);
        push_exp(5'd12, 32'h0, 1'b0, 1'b0, 1'b0);
        sample();
        advance();
        drive_idle();
        drive_resp(32'h0000_0BAD, 1'b1);
        sample();
        tests++; if (instr_done_wb_o !== 1'b1) begin fails++; $display("FAIL err_done: got %b required 1", instr_done_wb_o); end
        tests++; if (rf_we_wb_o !== 1'b0) begin fails++; $display("FAIL err_we: got %b required 0", rf_we_wb_o); end
        tests++; if (perf_instr_ret_wb_o !== 1'b0) begin fails++; $display("FAIL err_perf: got %b required 0", perf_instr_ret_wb_o); end
        advance();
        drive_idle();
        sample();
        tests++; if (outstanding_load_wb_o !== 1'b0) begin fails++; $display("FAIL err_outst: got %b required 0", outstanding_load_wb_o); end
        advance();
    endtask

    task automatic test_setback();
        drive_idle();
        drive_enq(WB_INSTR_LOAD, 5'd14, 32'h0, 1'b0, 1'b1, 1'b0, 32'h500);
        sample(); advance();
        drive_idle();
        drive_enq(WB_INSTR_STORE, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h504);
        sample(); advance();
        drive_idle();
        drive_enq(WB_INSTR_LOAD, 5'd15, 32'h0, 1'b0, 1'b1, 1'b0, 32'h508);
        sample(); advance();
        drive_idle();
        sample();
        tests++; if (occupancy_o !== OccW'(3)) begin fails++; $display("FAIL sb_pre_occ: got %0d required 3", occupancy_o); end
        tests++; if (outstanding_store_wb_o !== 1'b1) begin fails++; $display("FAIL sb_pre_store: got %b required 1", outstanding_store_wb_o); end
        tests++; if (rf_pending_wb_o !== 32'h0000_C000) begin fails++; $display("FAIL sb_pre_pending: got %h required 0000c000", rf_pending_wb_o); end
        tests++; if (pc_wb_o !== 32'h500) begin fails++; $display("FAIL sb_pre_pc: got %h required 00000500", pc_wb_o); end
        advance();
        setback_i = 1'b1;
        drive_resp(32'h0000_5555, 1'b0);
        sample();
        tests++; if (instr_done_wb_o !== 1'b0 || rf_we_wb_o !== 1'b0) begin fails++; $display("FAIL sb_suppress: got done=%b we=%b required 0/0", instr_done_wb_o, rf_we_wb_o); end
        advance();
        drive_idle();
        sample();
        tests++; if (occupancy_o !== '0) begin fails++; $display("FAIL sb_post_occ: got %0d required 0", occupancy_o); end
        tests++; if (outstanding_store_wb_o !== 1'b0 || rf_pending_wb_o !== 32'h0) begin fails++; $display("FAIL sb_post_state: got store=%b pending=%h required 0/0", outstanding_store_wb_o, rf_pending_wb_o); end
        advance();
        drive_resp(32'h0000_7777, 1'b0);
        sample();
        tests++; if (instr_done_wb_o !== 1'b0 || rf_we_wb_o !== 1'b0) begin fails++; $display("FAIL sb_stray: got done=%b we=%b required 0/0", instr_done_wb_o, rf_we_wb_o); end
        advance();
    endtask

    task automatic test_async_reset();
        drive_idle();
        drive_enq(WB_INSTR_LOAD, 5'd20, 32'h0, 1'b0, 1'b1, 1'b0, 32'h600);
        sample(); advance();
        drive_idle();
        drive_enq(WB_INSTR_LOAD, 5'd21, 32'h0, 1'b0, 1'b1, 1'b0, 32'h604);
        sample(); advance();
        drive_idle();
        #2;
        rst_i = 1'b1;
        #1;
        tests++; if (occupancy_o !== '0) begin fails++; $display("FAIL arst_occ: got %0d required 0", occupancy_o); end
        tests++; if (ready_wb_o !== 1'b1) begin fails++; $display("FAIL arst_ready: got %b required 1", ready_wb_o); end
        tests++; if (rf_pending_wb_o !== 32'h0 || outstanding_load_wb_o !== 1'b0) begin fails++; $display("FAIL arst_pending: got pending=%h load=%b required 0/0", rf_pending_wb_o, outstanding_load_wb_o); end
        tests++; if (pc_wb_o !== 32'h0) begin fails++; $display("FAIL arst_pc: got %h required 0", pc_wb_o); end
        sb.delete();
        @(negedge clk);
        #2;
        rst_i = 1'b0;
        advance();
        drive_resp(32'h0000_3333, 1'b0);
        sample();
        tests++; if (instr_done_wb_o !== 1'b0) begin fails++; $display("FAIL arst_stray: got %b required 0", instr_done_wb_o); end
        advance();
        drive_idle();
        drive_enq(WB_INSTR_OTHER, 5'd22, 32'h2222_0000, 1'b1, 1'b0, 1'b0, 32'h700);
        push_exp(5'd22, 32'h2222_0000, 1'b1, 1'b0, 1'b0);
        sample(); advance();
        drive_idle();
        sample();
        tests++; if (instr_done_wb_o !== 1'b1 || rf_waddr_wb_o !== 5'd22) begin fails++; $display("FAIL arst_resume: got done=%b waddr=%0d required done=1 waddr=22", instr_done_wb_o, rf_waddr_wb_o); end
        advance();
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL arst_sb_left: got %0d entries required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_bypass();
        test_full_wrap();
        test_load_error();
        test_setback();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
